// File: rtl/rvsteel_bus_pkg.sv
// Shared types and width constants for the RVSteel bus initiator slice.
package rvsteel_bus_pkg;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int STRB_W  = 4;
    localparam int TMO_W   = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } bus_state_e;

    // Reads never drive byte enables onto the bus.
    function automatic logic [STRB_W-1:0] fwd_strobe(input logic write, input logic [STRB_W-1:0] strobe);
        return write ? strobe : '0;
    endfunction

endpackage

// File: rtl/rvsteel_bus_initiator_if.sv
// Command/response handshake and memory-bus signals of the initiator.
interface rvsteel_bus_initiator_if;
    import rvsteel_bus_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_address;
    logic [DATA_W-1:0] cmd_wdata;
    logic [STRB_W-1:0] cmd_strobe;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_error;

    logic [ADDR_W-1:0] rw_address;
    logic [DATA_W-1:0] read_data;
    logic              read_request;
    logic              read_response;
    logic [DATA_W-1:0] write_data;
    logic [STRB_W-1:0] write_strobe;
    logic              write_request;
    logic              write_response;

    // The initiator itself.
    modport master (
        input  cmd_valid, cmd_write, cmd_address, cmd_wdata, cmd_strobe,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_error,
        input  rsp_ready,
        output rw_address, read_request, write_data, write_strobe, write_request,
        input  read_data, read_response, write_response
    );

    // Command source plus bus responder side.
    modport slave (
        output cmd_valid, cmd_write, cmd_address, cmd_wdata, cmd_strobe,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_error,
        output rsp_ready,
        input  rw_address, read_request, write_data, write_strobe, write_request,
        output read_data, read_response, write_response
    );

endinterface

// File: rtl/rvsteel_bus_timeout.sv
// WAIT-cycle counter; expired_o flags the last cycle a response may arrive.
module rvsteel_bus_timeout
    import rvsteel_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam logic [TMO_W-1:0] LIMIT = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] count_q;
    logic [TMO_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != LIMIT)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == LIMIT);

endmodule

// File: rtl/rvsteel_bus_initiator.sv
// Turns one command into one bus request and returns a single response.
//   state | meaning
//   IDLE  | cmd_ready high, waiting for a command
//   REQ   | one-cycle read_request or write_request pulse
//   WAIT  | waiting for the matching response or the timeout
//   RESP  | rsp_valid held until rsp_ready
module rvsteel_bus_initiator
    import rvsteel_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                     clock,
    input  logic                     reset,
    rvsteel_bus_initiator_if.master  bus
);

    bus_state_e        state_q;
    logic              write_q;
    logic              cmd_ready_q;
    logic              read_request_q;
    logic              write_request_q;
    logic              rsp_valid_q;
    logic              rsp_error_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic [ADDR_W-1:0] rw_address_q;
    logic [DATA_W-1:0] write_data_q;
    logic [STRB_W-1:0] write_strobe_q;

    logic              rsp_match;
    logic              tmo_expired;

    // Only the response for the operation in flight counts.
    assign rsp_match = write_q ? bus.write_response : bus.read_response;

    rvsteel_bus_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clock     (clock),
        .reset     (reset),
        .clear_i   (state_q == ST_REQ),
        .enable_i  ((state_q == ST_WAIT) && !rsp_match),
        .expired_o (tmo_expired)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            write_q         <= 1'b0;
            cmd_ready_q     <= 1'b1;
            read_request_q  <= 1'b0;
            write_request_q <= 1'b0;
            rsp_valid_q     <= 1'b0;
            rsp_error_q     <= 1'b0;
            rsp_rdata_q     <= '0;
            rw_address_q    <= '0;
            write_data_q    <= '0;
            write_strobe_q  <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.cmd_valid) begin
                        write_q         <= bus.cmd_write;
                        rw_address_q    <= bus.cmd_address;
                        write_data_q    <= bus.cmd_wdata;
                        write_strobe_q  <= fwd_strobe(bus.cmd_write, bus.cmd_strobe);
                        read_request_q  <= !bus.cmd_write;
                        write_request_q <= bus.cmd_write;
                        cmd_ready_q     <= 1'b0;
                        state_q         <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    read_request_q  <= 1'b0;
                    write_request_q <= 1'b0;
                    state_q         <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A response on the deadline cycle wins over the timeout.
                    if (rsp_match) begin
                        rsp_rdata_q <= write_q ? '0 : bus.read_data;
                        rsp_error_q <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= ST_RESP;
                    end else if (tmo_expired) begin
                        rsp_rdata_q <= '0;
                        rsp_error_q <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        state_q     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready     = cmd_ready_q;
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_rdata     = rsp_rdata_q;
    assign bus.rsp_error     = rsp_error_q;
    assign bus.rw_address    = rw_address_q;
    assign bus.read_request  = read_request_q;
    assign bus.write_data    = write_data_q;
    assign bus.write_strobe  = write_strobe_q;
    assign bus.write_request = write_request_q;

endmodule

// File: doc/rvsteel_bus_initiator.md
RVSTEEL_BUS_INITIATOR -- requirements
Module: rvsteel_bus_initiator

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: number of WAIT cycles without a response before a transaction fails; legal range 1..65535.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 cmd_valid  input  1  command offered.
REQ-005 cmd_ready  output  1  command accepted when high together with cmd_valid.
REQ-006 cmd_write  input  1  1 = write, 0 = read.
REQ-007 cmd_address  input  32  target byte address.
REQ-008 cmd_wdata  input  32  write data.
REQ-009 cmd_strobe  input  4  byte-enable for writes.
REQ-010 rsp_valid  output  1  result available.
REQ-011 rsp_ready  input  1  result consumed when high together with rsp_valid.
REQ-012 rsp_rdata  output  32  read data; 0 for writes and for errors.
REQ-013 rsp_error  output  1  1 = timeout.
REQ-014 rw_address  output  32  bus address.
REQ-015 read_data  input  32  bus read data.
REQ-016 read_request  output  1  bus read request.
REQ-017 read_response  input  1  bus read completion.
REQ-018 write_data  output  32  bus write data.
REQ-019 write_strobe  output  4  bus byte-enable.
REQ-020 write_request  output  1  bus write request.
REQ-021 write_response  input  1  bus write completion.

Function
REQ-022 The FSM SHALL have states IDLE, REQ, WAIT and RESP.
REQ-023 cmd_ready SHALL be 1 only in IDLE; cmd_valid && cmd_ready SHALL latch all cmd_* fields and move to REQ.
REQ-024 In REQ, exactly one of read_request or write_request SHALL be high for exactly one cycle; next state is WAIT.
REQ-025 rw_address, write_data and write_strobe SHALL hold the latched values from REQ until the next accepted command; write_strobe SHALL be 0 for reads.
REQ-026 In WAIT, the FSM SHALL sample only the response matching the operation (read_response for reads, write_response for writes).
- read: capture read_data into rsp_rdata, rsp_error=0.
- write: rsp_rdata=0, rsp_error=0.
- next state: RESP.
REQ-027 Response inputs in IDLE, REQ or RESP, and non-matching responses in WAIT, SHALL be ignored.
REQ-028 A 16-bit counter SHALL clear on entry to WAIT and increment each WAIT cycle without a matching response.
- If the counter reaches TIMEOUT_CYCLES-1 with no response, the next state is RESP with rsp_error=1 and rsp_rdata=0.
- A response arriving on that same cycle SHALL take priority over the timeout.
REQ-029 In RESP, rsp_valid SHALL be 1 and rsp_rdata/rsp_error SHALL be stable until rsp_ready; rsp_valid && rsp_ready SHALL return the FSM to IDLE.
REQ-030 Latency with a single-cycle responder and rsp_ready=1:
- cycle 0: command handshake
- cycle 1: request
- cycle 2: response
- cycle 3: rsp_valid
- cycle 4: cmd_ready again
REQ-031 Addresses and strobes SHALL be forwarded unmodified; alignment checking is the responder's job.

Reset
REQ-032 Reset SHALL force IDLE and set the following outputs to 0: read_request, write_request, rsp_valid, rsp_error, rsp_rdata, rw_address, write_data, write_strobe and the timeout counter.
REQ-033 Reset in REQ, WAIT or RESP SHALL discard the transaction with no rsp_valid pulse; a response arriving after reset SHALL be ignored per REQ-027.

Structure
REQ-034 State encodings (2-bit) and the bus width constants (address 32, data 32, strobe 4) SHALL live in the shared package rvsteel_bus_pkg.
REQ-035 One sub-module is natural: rvsteel_bus_timeout (counter with clear, enable and expired output, parameterized by TIMEOUT_CYCLES); everything else stays flat.

Verification
REQ-036 Write/read loopback to GPIO responder: write 0x0000000F to addr 0x04 with strobe 0xF, then read 0x04 -> one write_request pulse, rsp_error=0, gpio_oe=0xF; read gives rsp_rdata=0x0000000F at cycle 3.
REQ-037 Timeout: TIMEOUT_CYCLES=4, responder silent, read 0x10 -> rsp_valid after 4 WAIT cycles, rsp_error=1, rsp_rdata=0; next command accepted afterwards.
REQ-038 Response at the deadline: TIMEOUT_CYCLES=4, read_response with read_data 0xA5A5A5A5 on the 4th WAIT cycle -> rsp_error=0, rsp_rdata=0xA5A5A5A5.
REQ-039 Backpressure:
- Hold rsp_ready=0 for 10 cycles -> rsp_valid and data stable, cmd_ready=0 throughout, no further bus request.
- Then rsp_ready=1 -> IDLE next cycle.
REQ-040 Reset mid-WAIT: assert reset during WAIT, then drive write_response the cycle after reset deasserts -> no rsp_valid, all outputs 0, cmd_ready=1.
REQ-041 Stray responses: pulse read_response in IDLE, and during a write in WAIT -> ignored; the write completes only on write_response.
